// File: rtl/dump_sender_if.sv
// Handshake bundle between the dump address generator/transmitter and dump_sender.
// Latency: none (plain wires).
// Backpressure: o_ready tells the producer when a new word may be presented.
interface dump_sender_if #(
    parameter int DATA_SIZE = 16,
    parameter int BYTE_SIZE = 8
);
    logic                 i_valid;
    logic                 i_end;
    logic [DATA_SIZE-1:0] i_data;
    logic                 i_tx_done;
    logic                 o_tx_start;
    logic [BYTE_SIZE-1:0] o_tx_data;
    logic                 o_ready;
    logic                 o_busy;
    logic                 o_overrun;

    // Producer / transmitter side: drives words and done pulses, observes status.
    modport master (
        output i_valid, i_end, i_data, i_tx_done,
        input  o_tx_start, o_tx_data, o_ready, o_busy, o_overrun
    );

    // dump_sender side.
    modport slave (
        input  i_valid, i_end, i_data, i_tx_done,
        output o_tx_start, o_tx_data, o_ready, o_busy, o_overrun
    );
endinterface

// File: rtl/dump_sender.sv
// Serialises captured memory words MSB-byte first to a byte transmitter, then a terminator byte on i_end.
// Latency: o_tx_start rises on the edge after an i_valid/i_end rise; next byte the edge after i_tx_done.
// Backpressure: o_ready low while a word/terminator is in flight; rises arriving while busy set sticky o_overrun.
module dump_sender #(
    parameter int                   DATA_SIZE = 16,
    parameter int                   BYTE_SIZE = 8,
    parameter logic [BYTE_SIZE-1:0] END_BYTE  = BYTE_SIZE'(8'h0A)
) (
    input  logic         i_clock,
    input  logic         i_reset,
    dump_sender_if.slave io_bus
);

    localparam int NBYTES = DATA_SIZE / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_TERM_START,
        S_TERM_WAIT
    } state_t;

    // Registered state and outputs
    state_t               r_state;
    logic                 r_valid_q;
    logic                 r_end_q;
    logic [DATA_SIZE-1:0] r_word;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_tx_start;
    logic [BYTE_SIZE-1:0] r_tx_data;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_overrun;

    // Next-state values
    state_t               w_state_nxt;
    logic [DATA_SIZE-1:0] w_word_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_tx_start_nxt;
    logic [BYTE_SIZE-1:0] w_tx_data_nxt;
    logic                 w_ready_nxt;
    logic                 w_busy_nxt;
    logic                 w_overrun_nxt;
    logic                 w_load_byte;
    logic [DATA_SIZE-1:0] w_shifted;

    logic                 w_valid_rise;
    logic                 w_end_rise;

    // A rise is the live level high against a low registered copy; reset clears the
    // copies so a level already high at release counts as a rise on the first edge.
    assign w_valid_rise = io_bus.i_valid & ~r_valid_q;
    assign w_end_rise   = io_bus.i_end   & ~r_end_q;

    // Next-state / next-output logic; outputs are loaded in step with the state they describe.
    always_comb begin
        w_state_nxt    = r_state;
        w_word_nxt     = r_word;
        w_cnt_nxt      = r_cnt;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_ready_nxt    = r_ready;
        w_overrun_nxt  = r_overrun;
        w_load_byte    = 1'b0;
        w_shifted      = '0;

        case (r_state)
            S_IDLE: begin
                // i_end wins; a simultaneous i_valid rise is silently dropped.
                if (w_end_rise) begin
                    w_state_nxt    = S_TERM_START;
                    w_tx_start_nxt = 1'b1;
                    w_tx_data_nxt  = END_BYTE;
                    w_ready_nxt    = 1'b0;
                end else if (w_valid_rise) begin
                    w_state_nxt = S_START;
                    w_word_nxt  = io_bus.i_data;
                    w_cnt_nxt   = '0;
                    w_ready_nxt = 1'b0;
                    w_load_byte = 1'b1;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (io_bus.i_tx_done) begin
                    if (r_cnt != LAST_BYTE) begin
                        w_state_nxt = S_START;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        w_load_byte = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_ready_nxt = 1'b1;
                    end
                end
            end
            S_TERM_START: begin
                w_state_nxt = S_TERM_WAIT;
            end
            S_TERM_WAIT: begin
                if (io_bus.i_tx_done) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
            end
        endcase

        // Any new request while a transfer is in flight is lost; remember that it happened.
        if ((r_state != S_IDLE) && (w_valid_rise || w_end_rise)) begin
            w_overrun_nxt = 1'b1;
        end

        // Byte counter 0 selects the top byte of the word, so shift left by 8*count.
        if (w_load_byte) begin
            w_shifted      = w_word_nxt << {w_cnt_nxt, 3'b000};
            w_tx_start_nxt = 1'b1;
            w_tx_data_nxt  = BYTE_SIZE'(w_shifted[DATA_SIZE-1 -: 8]);
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State, datapath and output registers; reset abandons any partial word.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_valid_q  <= 1'b0;
            r_end_q    <= 1'b0;
            r_word     <= '0;
            r_cnt      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_valid_q  <= io_bus.i_valid;
            r_end_q    <= io_bus.i_end;
            r_word     <= w_word_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    assign io_bus.o_tx_start = r_tx_start;
    assign io_bus.o_tx_data  = r_tx_data;
    assign io_bus.o_ready    = r_ready;
    assign io_bus.o_busy     = r_busy;
    assign io_bus.o_overrun  = r_overrun;

endmodule

// File: tb/tb_dump_sender.sv
// Directed bench for dump_sender: vector table for the plain flows, hand sequences for corner cases.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Expected values are hand-computed constants.
module tb_dump_sender;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dump_sender_if #(.DATA_SIZE(16), .BYTE_SIZE(8)) bus ();

    dump_sender #(
        .DATA_SIZE(16),
        .BYTE_SIZE(8),
        .END_BYTE (8'h0A)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .io_bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        v;
        logic        e;
        logic [15:0] d;
        logic        done;
        logic        st;
        logic [7:0]  dat;
        logic        rdy;
        logic        bsy;
        logic        ov;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic st, input logic [7:0] dat,
                             input logic rdy, input logic bsy, input logic ov);
        chk({tag, ".tx_start"}, 16'(bus.o_tx_start), 16'(st));
        chk({tag, ".tx_data"},  16'(bus.o_tx_data),  16'(dat));
        chk({tag, ".ready"},    16'(bus.o_ready),    16'(rdy));
        chk({tag, ".busy"},     16'(bus.o_busy),     16'(bsy));
        chk({tag, ".overrun"},  16'(bus.o_overrun),  16'(ov));
    endtask

    // Apply inputs, advance one edge, compare outputs.
    task automatic run(input string tag, input logic v, input logic e, input logic [15:0] d,
                       input logic done, input logic st, input logic [7:0] dat,
                       input logic rdy, input logic bsy, input logic ov);
        bus.i_valid   = v;
        bus.i_end     = e;
        bus.i_data    = d;
        bus.i_tx_done = done;
        @(posedge clk);
        #1;
        check_out(tag, st, dat, rdy, bsy, ov);
    endtask

    task automatic addv(input logic v, input logic e, input logic [15:0] d, input logic done,
                        input logic st, input logic [7:0] dat, input logic rdy,
                        input logic bsy, input logic ov);
        vec_t r;
        r.v = v; r.e = e; r.d = d; r.done = done;
        r.st = st; r.dat = dat; r.rdy = rdy; r.bsy = bsy; r.ov = ov;
        tbl.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- table ----------------
        //   v  e  data      done st dat    rdy bsy ov
        // single word A55A, valid 4 cycles, done 5 cycles after each start
        addv(1, 0, 16'hA55A, 0,   1, 8'hA5, 0,  1,  0);
        addv(1, 0, 16'hA55A, 0,   0, 8'hA5, 0,  1,  0);
        addv(1, 0, 16'hA55A, 0,   0, 8'hA5, 0,  1,  0);
        addv(1, 0, 16'hA55A, 0,   0, 8'hA5, 0,  1,  0);
        addv(0, 0, 16'hA55A, 0,   0, 8'hA5, 0,  1,  0);
        addv(0, 0, 16'hA55A, 1,   1, 8'h5A, 0,  1,  0);
        addv(0, 0, 16'hA55A, 0,   0, 8'h5A, 0,  1,  0);
        addv(0, 0, 16'hA55A, 0,   0, 8'h5A, 0,  1,  0);
        addv(0, 0, 16'hA55A, 0,   0, 8'h5A, 0,  1,  0);
        addv(0, 0, 16'hA55A, 0,   0, 8'h5A, 0,  1,  0);
        addv(0, 0, 16'hA55A, 1,   0, 8'h5A, 1,  0,  0);
        addv(0, 0, 16'hA55A, 0,   0, 8'h5A, 1,  0,  0);
        // end only
        addv(0, 1, 16'h0000, 0,   1, 8'h0A, 0,  1,  0);
        addv(0, 1, 16'h0000, 0,   0, 8'h0A, 0,  1,  0);
        addv(0, 0, 16'h0000, 1,   0, 8'h0A, 1,  0,  0);
        addv(0, 0, 16'h0000, 0,   0, 8'h0A, 1,  0,  0);
        // simultaneous valid + end rise: terminator only, no overrun
        addv(1, 1, 16'h1234, 0,   1, 8'h0A, 0,  1,  0);
        addv(1, 1, 16'h1234, 0,   0, 8'h0A, 0,  1,  0);
        addv(0, 0, 16'h1234, 1,   0, 8'h0A, 1,  0,  0);
        addv(0, 0, 16'h1234, 0,   0, 8'h0A, 1,  0,  0);
        addv(0, 0, 16'h1234, 0,   0, 8'h0A, 1,  0,  0);

        // ---------------- reset ----------------
        rst           = 1'b1;
        bus.i_valid   = 1'b0;
        bus.i_end     = 1'b0;
        bus.i_data    = '0;
        bus.i_tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 0, 8'h00, 1, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run($sformatf("vec%0d", i), tbl[i].v, tbl[i].e, tbl[i].d, tbl[i].done,
                tbl[i].st, tbl[i].dat, tbl[i].rdy, tbl[i].bsy, tbl[i].ov);
        end

        // ---------------- stray done in IDLE and START ----------------
        run("stray_idle",   0, 0, 16'h0102, 1,  0, 8'h0A, 1, 0, 0);
        run("stray_go",     1, 0, 16'h0102, 0,  1, 8'h01, 0, 1, 0);
        run("stray_start",  1, 0, 16'h0102, 1,  0, 8'h01, 0, 1, 0);
        run("stray_wait",   0, 0, 16'h0102, 0,  0, 8'h01, 0, 1, 0);
        run("stray_b1",     0, 0, 16'h0102, 1,  1, 8'h02, 0, 1, 0);
        run("stray_b1w",    0, 0, 16'h0102, 0,  0, 8'h02, 0, 1, 0);
        run("stray_end",    0, 0, 16'h0102, 1,  0, 8'h02, 1, 0, 0);
        run("stray_quiet",  0, 0, 16'h0102, 0,  0, 8'h02, 1, 0, 0);

        // ---------------- overrun: valid re-rises in WAIT ----------------
        run("ovr_go",       1, 0, 16'hC33C, 0,  1, 8'hC3, 0, 1, 0);
        run("ovr_wait",     0, 0, 16'hC33C, 0,  0, 8'hC3, 0, 1, 0);
        run("ovr_rerise",   1, 0, 16'hFFFF, 0,  0, 8'hC3, 0, 1, 1);
        run("ovr_b1",       0, 0, 16'hFFFF, 1,  1, 8'h3C, 0, 1, 1);
        run("ovr_b1w",      0, 0, 16'hFFFF, 0,  0, 8'h3C, 0, 1, 1);
        run("ovr_done",     0, 0, 16'hFFFF, 1,  0, 8'h3C, 1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            run($sformatf("ovr_idle%0d", k), 0, 0, 16'hFFFF, 0, 0, 8'h3C, 1, 0, 1);
        end

        // ---------------- reset mid-word, valid held through release ----------------
        run("rst_go",       1, 0, 16'hBEEF, 0,  1, 8'hBE, 0, 1, 1);
        run("rst_wait",     1, 0, 16'hBEEF, 0,  0, 8'hBE, 0, 1, 1);
        #2;
        rst        = 1'b1;
        bus.i_data = 16'h1357;
        #1;
        check_out("rst_async", 0, 8'h00, 1, 0, 0);
        @(posedge clk);
        #1;
        check_out("rst_held", 0, 8'h00, 1, 0, 0);
        rst = 1'b0;
        run("rel_rise",     1, 0, 16'h1357, 0,  1, 8'h13, 0, 1, 0);
        run("rel_wait",     0, 0, 16'h1357, 0,  0, 8'h13, 0, 1, 0);
        run("rel_b1",       0, 0, 16'h1357, 1,  1, 8'h57, 0, 1, 0);
        run("rel_b1w",      0, 0, 16'h1357, 0,  0, 8'h57, 0, 1, 0);
        run("rel_done",     0, 0, 16'h1357, 1,  0, 8'h57, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dump_sender.md
DUMP_SENDER -- requirements
Module: dump_sender

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 16, giving the memory word width; it SHALL be a multiple of 8 and at least 8.
REQ-002 The block SHALL have parameter BYTE_SIZE, default 8, giving the transmitter byte width.
REQ-003 The block SHALL have parameter END_BYTE, default 8'h0A, giving the terminator byte sent when a dump completes.
REQ-004 i_clock  input  1  single clock; all state SHALL change on its rising edge except reset.
REQ-005 i_reset  input  1  reset; asynchronous, active-high.
REQ-006 i_valid  input  1  dump address valid; the word on i_data is valid while high, held at least 2 cycles.
REQ-007 i_end  input  1  dump finished indication from the address generator.
REQ-008 i_data  input  DATA_SIZE  memory read word for the current dump address.
REQ-009 i_tx_done  input  1  one-cycle pulse from the byte transmitter when the current byte has been sent.
REQ-010 o_tx_start  output  1  one-cycle request to the byte transmitter.
REQ-011 o_tx_data  output  BYTE_SIZE  byte to transmit; SHALL be stable from o_tx_start until the matching i_tx_done.
REQ-012 o_ready  output  1  high when the previous word has been fully sent and a new word can be accepted.
REQ-013 o_busy  output  1  high in any state other than IDLE.
REQ-014 o_overrun  output  1  sticky flag: a rising i_valid or i_end arrived while busy.

Function
REQ-015 Every output SHALL be driven from a register.
REQ-016 States SHALL be IDLE, START, WAIT, TERM_START and TERM_WAIT.
REQ-017 i_valid and i_end SHALL each be edge-detected against a registered copy; a rise is the current value 1 with the registered copy 0.
REQ-018 IDLE, on an i_end rise, SHALL go to TERM_START and drive o_ready=0; i_end SHALL have priority over a simultaneous i_valid rise, which is dropped.
REQ-019 IDLE, on an i_valid rise without an i_end rise, SHALL perform the following on that edge:
- capture i_data into the word register;
- clear the byte counter to 0;
- drive o_ready=0;
- go to START.
REQ-020 START SHALL, for one cycle, drive o_tx_start=1 and o_tx_data = byte selected by the byte counter, then go to WAIT.
REQ-021 Bytes SHALL be sent MSB first: counter 0 selects i_data[DATA_SIZE-1 -: 8] of the captured word.
REQ-022 WAIT SHALL hold o_tx_start=0 and o_tx_data unchanged until i_tx_done=1, then take one of two paths:
- if the counter is below DATA_SIZE/8-1: increment the counter and go to START;
- otherwise: go to IDLE and set o_ready=1.
REQ-023 TERM_START SHALL, for one cycle, drive o_tx_start=1 and o_tx_data=END_BYTE, then go to TERM_WAIT.
REQ-024 TERM_WAIT SHALL wait for i_tx_done=1, then go to IDLE and set o_ready=1.
REQ-025 An i_tx_done pulse in IDLE, START or TERM_START SHALL be ignored.
REQ-026 An i_valid or i_end rise outside IDLE SHALL be ignored for data purposes and SHALL set o_overrun=1; only reset clears o_overrun.
REQ-027 i_valid held high across several cycles SHALL produce exactly one word transfer.
REQ-028 o_busy SHALL equal (state != IDLE), registered coherently with the state.

Reset
REQ-029 Asserting i_reset at any time, including mid-word, SHALL immediately force all of the following, and no partial byte SHALL be resumed after release:
- state IDLE;
- o_ready=1;
- o_busy=0;
- o_tx_start=0;
- o_tx_data=0;
- o_overrun=0;
- byte counter, word register and edge-detect registers to 0.
REQ-030 After reset release, an i_valid already high SHALL count as a rise on the first clock edge.

Verification
REQ-031 Single word: i_data=16'hA55A with i_valid high 4 cycles, i_tx_done 5 cycles after each o_tx_start -> required response:
- o_tx_start pulses twice, with bytes 8'hA5 then 8'h5A;
- o_ready low from the edge after the rise until the edge after the second i_tx_done;
- o_overrun=0.
REQ-032 End only: i_end rises in IDLE -> one o_tx_start with o_tx_data=8'h0A; after i_tx_done, o_ready=1 and state IDLE.
REQ-033 Simultaneous: i_valid and i_end rise on the same edge -> only 8'h0A is sent and o_overrun stays 0.
REQ-034 Overrun: i_valid re-rises while in WAIT -> o_overrun=1, the current word completes unchanged, and the second word is not sent.
REQ-035 Reset mid-word: i_reset pulsed during WAIT of byte 0 -> all outputs at reset values at once; the next word sends from byte 0.
REQ-036 Stray done: i_tx_done pulsed in IDLE and START -> no state change and no extra o_tx_start.
